// File: rtl/uart_pkg.sv
// Shared constants for the UART TX DMA: UART register map, CSR map,
// control/status bit positions and the DMA sequencer state encoding.
package uart_pkg;

    localparam logic [31:0] UART_TX_OFF       = 32'h0000_0000;
    localparam logic [31:0] UART_STAT_OFF     = 32'h0000_0008;
    localparam int          UART_TX_READY_BIT = 1;

    localparam logic [31:0] CSR_SRC_OFF    = 32'h0000_0000;
    localparam logic [31:0] CSR_LEN_OFF    = 32'h0000_0004;
    localparam logic [31:0] CSR_CTRL_OFF   = 32'h0000_0008;
    localparam logic [31:0] CSR_STATUS_OFF = 32'h0000_000C;
    localparam logic [31:0] CSR_REMAIN_OFF = 32'h0000_0010;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_ABORT   = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_POLL  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } dma_state_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        apply_wstrb = {strb[3] ? new_val[31:24] : old_val[31:24],
                       strb[2] ? new_val[23:16] : old_val[23:16],
                       strb[1] ? new_val[15:8]  : old_val[15:8],
                       strb[0] ? new_val[7:0]   : old_val[7:0]};
    endfunction

endpackage

// File: rtl/uart_dma_csr.sv
// CSR slave for the UART TX DMA: address decode, SRC/LEN/CTRL registers,
// sticky done/aborted flags and the registered interrupt line.
module uart_dma_csr
    import uart_pkg::*;
#(
    parameter logic [31:0] CSR_BASE = 32'h8100_2000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    input  logic [31:0] i_s_addr,
    input  logic [31:0] i_s_wdata,
    input  logic [3:0]  i_s_wstrb,
    output logic [31:0] o_s_rdata,
    input  logic        i_busy,
    input  logic [15:0] i_remain,
    input  logic        i_done_set,
    input  logic        i_aborted_set,
    input  logic        i_eoi,
    output logic [31:0] o_src,
    output logic [15:0] o_len,
    output logic        o_start,
    output logic        o_abort,
    output logic        o_irq
);

    logic [31:0] r_src;
    logic [15:0] r_len;
    logic        r_irq_en;
    logic        r_done;
    logic        r_aborted;
    logic        r_start;
    logic        r_abort;
    logic        r_s_ready;
    logic [31:0] r_rdata;
    logic        r_irq;

    logic [31:0] w_off;
    logic        w_req;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_rd_val;
    logic [31:0] w_len_new;
    logic        w_ctrl_wr;
    logic        w_stat_wr;
    logic        w_irq_en_nxt;
    logic        w_done_nxt;
    logic        w_aborted_nxt;

    assign w_off     = i_s_addr - CSR_BASE;
    assign w_req     = i_s_valid & ~r_s_ready;
    assign w_wr      = w_req & (i_s_wstrb != 4'b0000);
    assign w_rd      = w_req & (i_s_wstrb == 4'b0000);
    assign w_ctrl_wr = w_wr & (w_off == CSR_CTRL_OFF) & i_s_wstrb[0];
    assign w_stat_wr = w_wr & (w_off == CSR_STATUS_OFF) & i_s_wstrb[0];
    assign w_len_new = apply_wstrb({16'b0, r_len}, i_s_wdata, i_s_wstrb);

    // Hardware set wins over a W1C write or eoi landing in the same cycle.
    assign w_irq_en_nxt  = w_ctrl_wr ? i_s_wdata[CTRL_IRQ_EN] : r_irq_en;
    assign w_done_nxt    = i_done_set |
                           (r_done & ~(i_eoi | (w_stat_wr & i_s_wdata[STAT_DONE])));
    assign w_aborted_nxt = i_aborted_set |
                           (r_aborted & ~(i_eoi | (w_stat_wr & i_s_wdata[STAT_ABORTED])));

    always_comb begin
        w_rd_val = '0;
        case (w_off)
            CSR_SRC_OFF:    w_rd_val = r_src;
            CSR_LEN_OFF:    w_rd_val = {16'b0, r_len};
            CSR_CTRL_OFF:   w_rd_val[CTRL_IRQ_EN] = r_irq_en;
            CSR_STATUS_OFF: begin
                w_rd_val[STAT_BUSY]    = i_busy;
                w_rd_val[STAT_DONE]    = r_done;
                w_rd_val[STAT_ABORTED] = r_aborted;
            end
            CSR_REMAIN_OFF: w_rd_val = {16'b0, i_remain};
            default:        w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_src     <= '0;
            r_len     <= '0;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_start   <= 1'b0;
            r_abort   <= 1'b0;
            r_s_ready <= 1'b0;
            r_rdata   <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_s_ready <= w_req;
            r_rdata   <= w_rd ? w_rd_val : 32'b0;
            r_start   <= w_ctrl_wr & i_s_wdata[CTRL_START] & ~i_busy;
            r_abort   <= w_ctrl_wr & i_s_wdata[CTRL_ABORT];
            if (w_wr && !i_busy && (w_off == CSR_SRC_OFF))
                r_src <= apply_wstrb(r_src, i_s_wdata, i_s_wstrb);
            if (w_wr && !i_busy && (w_off == CSR_LEN_OFF))
                r_len <= w_len_new[15:0];
            r_irq_en  <= w_irq_en_nxt;
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
            r_irq     <= w_irq_en_nxt & (w_done_nxt | w_aborted_nxt);
        end
    end

    assign o_s_ready = r_s_ready;
    assign o_s_rdata = r_rdata;
    assign o_src     = r_src;
    assign o_len     = r_len;
    assign o_start   = r_start;
    assign o_abort   = r_abort;
    assign o_irq     = r_irq;

endmodule

// File: rtl/uart_tx_dma.sv
// DMA engine that streams LEN bytes from memory at SRC into a UART TX
// register, polling the UART ready flag before every byte.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | reading the aligned memory word holding the next byte
// POLL  | reading UART status until tx_ready is set
// SEND  | writing one byte to the UART TX register
// DONE  | one-cycle completion, sets done
module uart_tx_dma
    import uart_pkg::*;
#(
    parameter logic [31:0] UART_BASE = 32'h8100_1000,
    parameter logic [31:0] CSR_BASE  = 32'h8100_2000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic [31:0] s_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    output logic        irq,
    input  logic        eoi
);

    dma_state_t  r_state;
    dma_state_t  w_state_nxt;

    logic [31:0] r_ptr;
    logic [31:0] r_word;
    logic [15:0] r_remain;
    logic        r_abort_req;
    logic        r_m_valid;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic [3:0]  r_m_wstrb;

    logic [31:0] w_src;
    logic [15:0] w_len;
    logic        w_start;
    logic        w_abort;
    logic        w_busy;
    logic        w_xfer_done;
    logic        w_abort_pend;
    logic        w_between;
    logic        w_tx_ready;
    logic [31:0] w_ptr_inc;
    logic [7:0]  w_lane;
    logic        w_issue;
    logic [31:0] w_issue_addr;
    logic [31:0] w_issue_wdata;
    logic [3:0]  w_issue_wstrb;
    logic        w_load;
    logic        w_done_set;
    logic        w_aborted_set;

    uart_dma_csr #(.CSR_BASE(CSR_BASE)) u_csr (
        .clk           (clk),
        .resetn        (resetn),
        .i_s_valid     (s_valid),
        .o_s_ready     (s_ready),
        .i_s_addr      (s_addr),
        .i_s_wdata     (s_wdata),
        .i_s_wstrb     (s_wstrb),
        .o_s_rdata     (s_rdata),
        .i_busy        (w_busy),
        .i_remain      (r_remain),
        .i_done_set    (w_done_set),
        .i_aborted_set (w_aborted_set),
        .i_eoi         (eoi),
        .o_src         (w_src),
        .o_len         (w_len),
        .o_start       (w_start),
        .o_abort       (w_abort),
        .o_irq         (irq)
    );

    assign w_busy       = (r_state != ST_IDLE);
    assign w_xfer_done  = r_m_valid & m_ready;
    assign w_abort_pend = r_abort_req | (w_abort & w_busy);
    // Abort only takes effect while no master transaction is outstanding.
    assign w_between    = ~r_m_valid & w_abort_pend;
    assign w_tx_ready   = m_rdata[UART_TX_READY_BIT];
    assign w_ptr_inc    = r_ptr + 32'd1;

    always_comb begin
        w_lane = r_word[7:0];
        case (r_ptr[1:0])
            2'd1:    w_lane = r_word[15:8];
            2'd2:    w_lane = r_word[23:16];
            2'd3:    w_lane = r_word[31:24];
            default: w_lane = r_word[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start && (w_len != 16'd0))
                    w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_xfer_done)
                    w_state_nxt = ST_POLL;
                else if (w_between)
                    w_state_nxt = ST_IDLE;
            end
            ST_POLL: begin
                if (w_xfer_done) begin
                    if (w_tx_ready)
                        w_state_nxt = ST_SEND;
                end else if (w_between) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_xfer_done) begin
                    if (r_remain <= 16'd1)
                        w_state_nxt = ST_DONE;
                    else if (w_ptr_inc[1:0] == 2'b00)
                        w_state_nxt = ST_FETCH;
                    else
                        w_state_nxt = ST_POLL;
                end else if (w_between) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue       = 1'b0;
        w_issue_addr  = '0;
        w_issue_wdata = '0;
        w_issue_wstrb = '0;
        w_load        = 1'b0;
        w_done_set    = 1'b0;
        w_aborted_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load     = w_start;
                w_done_set = w_start & (w_len == 16'd0);
            end
            ST_FETCH: begin
                w_issue       = ~r_m_valid & ~w_abort_pend;
                w_issue_addr  = {r_ptr[31:2], 2'b00};
                w_aborted_set = w_between;
            end
            ST_POLL: begin
                w_issue       = ~r_m_valid & ~w_abort_pend;
                w_issue_addr  = UART_BASE + UART_STAT_OFF;
                w_aborted_set = w_between;
            end
            ST_SEND: begin
                w_issue       = ~r_m_valid & ~w_abort_pend;
                w_issue_addr  = UART_BASE + UART_TX_OFF;
                w_issue_wdata = {24'b0, w_lane};
                w_issue_wstrb = 4'b0001;
                w_aborted_set = w_between;
            end
            ST_DONE: w_done_set = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr       <= '0;
            r_word      <= '0;
            r_remain    <= '0;
            r_abort_req <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_m_wstrb   <= '0;
        end else begin
            if (w_load) begin
                r_ptr    <= w_src;
                r_remain <= w_len;
            end
            if (!w_busy)
                r_abort_req <= 1'b0;
            else if (w_abort)
                r_abort_req <= 1'b1;
            if (w_issue) begin
                r_m_valid <= 1'b1;
                r_m_addr  <= w_issue_addr;
                r_m_wdata <= w_issue_wdata;
                r_m_wstrb <= w_issue_wstrb;
            end else if (w_xfer_done) begin
                r_m_valid <= 1'b0;
                if (r_state == ST_FETCH)
                    r_word <= m_rdata;
                if (r_state == ST_SEND) begin
                    r_ptr <= w_ptr_inc;
                    if (r_remain != 16'd0)
                        r_remain <= r_remain - 16'd1;
                end
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_wstrb = r_m_wstrb;

endmodule

// File: doc/uart_tx_dma.md
UART_TX_DMA -- requirements
Module: uart_tx_dma

Interface
REQ-001 SHALL have parameter UART_BASE, default 32'h8100_1000, base address of the UART register block on the master bus.
REQ-002 SHALL have parameter CSR_BASE, default 32'h8100_2000, base address of this block's CSR slave window.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset: synchronous, active-low.
REQ-005 SHALL have CSR slave ports s_valid in 1, s_ready out 1, s_addr in 32, s_wdata in 32, s_wstrb in 4, s_rdata out 32; s_wstrb==0 means read.
REQ-006 SHALL have master ports m_valid out 1, m_ready in 1, m_addr out 32, m_wdata out 32, m_wstrb out 4, m_rdata in 32.
REQ-007 SHALL have irq out 1 (level interrupt) and eoi in 1 (end-of-interrupt).

Function
REQ-008 CSR map, offsets from CSR_BASE: 0x00 SRC RW; 0x04 LEN RW, bits[15:0]; 0x08 CTRL (bit0 start W1, self-clearing; bit1 irq_en RW; bit2 abort W1, self-clearing); 0x0C STATUS (bit0 busy RO, bit1 done W1C, bit2 aborted W1C); 0x10 REMAIN RO, bits[15:0]; all other offsets read 0, writes ignored.
REQ-009 s_ready SHALL pulse high one cycle after s_valid is sampled while s_ready is low; s_rdata is valid in that cycle and 0 otherwise.
REQ-010 Writes to SRC/LEN while busy SHALL be ignored; start while busy SHALL be ignored.
REQ-011 FSM states: IDLE, FETCH, POLL, SEND, DONE.
REQ-012 IDLE->FETCH on start with LEN!=0: latch ptr=SRC, remain=LEN, busy=1.
REQ-013 start with LEN==0 SHALL set done the next cycle with no master transaction.
REQ-014 FETCH: word read at {ptr[31:2],2'b00}, m_wstrb=0; latch m_rdata on m_ready; go to POLL.
REQ-015 POLL: read UART_BASE+0x08; bit1 (tx_ready) set -> SEND, clear -> reissue POLL.
REQ-016 SEND: write UART_BASE+0x00, m_wstrb=4'b0001, m_wdata={24'b0, word byte lane ptr[1:0]} (little-endian); on m_ready: ptr+=1, remain-=1.
REQ-017 After SEND: remain==0 -> DONE; else ptr[1:0]==0 -> FETCH; else POLL.
REQ-018 A non-aligned SRC SHALL begin at lane SRC[1:0]; each word is fetched at most once.
REQ-019 DONE: set done, clear busy, go to IDLE in one cycle.
REQ-020 Master handshake: m_valid, m_addr, m_wdata and m_wstrb stay stable until m_ready is sampled high; m_valid is low for at least one cycle between transactions.
REQ-021 abort while busy: the outstanding master transaction SHALL complete; then set aborted, clear busy, go to IDLE, leave done clear; REMAIN keeps the unsent count.
REQ-022 irq SHALL be registered as irq_en & (done | aborted); eoi high SHALL clear done and aborted (irq low the next cycle).
REQ-023 A same-cycle W1C write and hardware set SHALL leave the bit set.
REQ-024 ptr SHALL wrap modulo 2^32; remain is 16-bit and never underflows.

Reset
REQ-025 Reset SHALL force IDLE, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, s_ready=0, s_rdata=0, irq=0, and clear SRC, LEN, CTRL, STATUS and REMAIN.
REQ-026 Reset mid-transfer SHALL abandon the transaction immediately, with no further master activity.

Structure
REQ-027 The UART register offsets, CSR offsets, CTRL/STATUS bit indices and FSM state encoding SHALL live in shared package uart_pkg.
REQ-028 One sub-module is natural: uart_dma_csr (slave decode and register file); the FSM and master port stay in the top level.

Verification
REQ-029 SRC=0x100, LEN=3, memory[0x100]=0x44332211, UART always ready -> one FETCH, UART_TX writes 0x11,0x22,0x33, then done=1, REMAIN=0.
REQ-030 SRC=0x103, LEN=2 -> fetches 0x100 then 0x104; sends lane3 then lane0 of the next word.
REQ-031 UART status bit1=0 for 5 polls, then 1 -> exactly 6 POLL reads before each SEND; no write while not ready.
REQ-032 LEN=0 start -> done the next cycle, zero master transactions; irq_en=1 -> irq=1; eoi -> irq=0, done=0.
REQ-033 LEN=8, abort after the 2nd byte is accepted -> the in-flight transaction completes, aborted=1, done=0, REMAIN=6 (or 5 if the 3rd write was in flight).
REQ-034 resetn low mid-SEND with m_ready held low -> m_valid=0 the next cycle, STATUS=0; a subsequent start behaves normally.
